// File: rtl/easyaxi_rd_slv_if.sv
// AXI4 read channels (AR + R) between EasyAXI master and read slave.
// master drives AR and r_ready; slave drives ar_ready and all of R.
interface easyaxi_rd_slv_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  axi_ar_valid;
  logic                  axi_ar_ready;
  logic [ID_WIDTH-1:0]   axi_ar_id;
  logic [ADDR_WIDTH-1:0] axi_ar_addr;
  logic [7:0]            axi_ar_len;
  logic [2:0]            axi_ar_size;
  logic [1:0]            axi_ar_burst;
  logic                  axi_r_valid;
  logic                  axi_r_ready;
  logic [ID_WIDTH-1:0]   axi_r_id;
  logic [DATA_WIDTH-1:0] axi_r_data;
  logic [1:0]            axi_r_resp;
  logic                  axi_r_last;

  modport master (
    output axi_ar_valid,
    output axi_ar_id,
    output axi_ar_addr,
    output axi_ar_len,
    output axi_ar_size,
    output axi_ar_burst,
    output axi_r_ready,
    input  axi_ar_ready,
    input  axi_r_valid,
    input  axi_r_id,
    input  axi_r_data,
    input  axi_r_resp,
    input  axi_r_last
  );

  modport slave (
    input  axi_ar_valid,
    input  axi_ar_id,
    input  axi_ar_addr,
    input  axi_ar_len,
    input  axi_ar_size,
    input  axi_ar_burst,
    input  axi_r_ready,
    output axi_ar_ready,
    output axi_r_valid,
    output axi_r_id,
    output axi_r_data,
    output axi_r_resp,
    output axi_r_last
  );
endinterface

// File: rtl/easyaxi_rd_slv.sv
// AXI4 read responder: AR queue + in-order R bursts, data = addr ^ seed.
// Ports: clk, rst (sync, active high), axi (slave modport, AR + R).
module easyaxi_rd_slv #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    AR_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 16'h1000,
  parameter logic [31:0]           DATA_SEED  = 32'hA5A5_0000
) (
  input logic             clk,
  input logic             rst,
  easyaxi_rd_slv_if.slave axi
);
  localparam int PW = $clog2(AR_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] MAX_SIZE =
    3'($clog2(DATA_WIDTH / 8));

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_t;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  ar_t                   r_q [AR_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_qcnt;
  logic                  r_ar_ready;
  state_t                r_state;
  ar_t                   r_cur;
  logic                  r_berr;
  logic [7:0]            r_cnt;
  logic                  r_valid;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;

  ar_t                   w_in;
  ar_t                   w_head;
  logic                  w_head_berr;
  logic [ADDR_WIDTH-1:0] w_nxt;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_rhs;
  logic                  w_end;
  logic                  w_pop;
  logic [CW-1:0]         w_qcnt_nxt;

  function automatic logic f_berr(input ar_t a);
    logic [ADDR_WIDTH-1:0] m;
    logic                  wlen;
    m    = (ADDR_WIDTH'(1) << a.size) - ADDR_WIDTH'(1);
    wlen = a.len inside {8'd1, 8'd3, 8'd7, 8'd15};
    return (a.burst == 2'd3) ||
           (a.size > MAX_SIZE) ||
           (a.burst == 2'd2 &&
            (!wlen || (a.addr & m) != '0));
  endfunction

  // WRAP keeps the upper bits of the start window and
  // takes the low bits from the INCR result.
  function automatic logic [ADDR_WIDTH-1:0] f_next(
    input ar_t c
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] wm;
    step = ADDR_WIDTH'(1) << c.size;
    inc  = (c.addr & ~(step - ADDR_WIDTH'(1))) + step;
    wm   = ((ADDR_WIDTH'(c.len) + ADDR_WIDTH'(1))
           << c.size) - ADDR_WIDTH'(1);
    unique case (c.burst)
      2'd0:    return c.addr;
      2'd2:    return (c.addr & ~wm) | (inc & wm);
      default: return inc;
    endcase
  endfunction

  function automatic logic [1:0] f_resp(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  e
  );
    if (e) return 2'b10;
    if (a >= ADDR_LIMIT) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_data(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  e
  );
    if (f_resp(a, e) != 2'b00) return '0;
    return DATA_WIDTH'(a) ^ DATA_WIDTH'(DATA_SEED);
  endfunction

  assign w_in.id      = axi.axi_ar_id;
  assign w_in.addr    = axi.axi_ar_addr;
  assign w_in.len     = axi.axi_ar_len;
  assign w_in.size    = axi.axi_ar_size;
  assign w_in.burst   = axi.axi_ar_burst;

  assign w_head       = r_q[r_rptr];
  assign w_head_berr  = f_berr(w_head);
  assign w_nxt        = f_next(r_cur);
  assign w_empty      = (r_qcnt == '0);
  assign w_push       = axi.axi_ar_valid & r_ar_ready;
  assign w_rhs        = r_valid & axi.axi_r_ready;
  assign w_end        = w_rhs && (r_cnt == r_cur.len);
  // A burst leaves the queue when it starts from IDLE or
  // when the previous burst's last beat is taken.
  assign w_pop        = !w_empty &&
                        ((r_state == S_IDLE) ||
                         (r_state == S_BURST && w_end));
  assign w_qcnt_nxt   = r_qcnt + CW'(w_push) - CW'(w_pop);

  assign axi.axi_ar_ready = r_ar_ready;
  assign axi.axi_r_valid  = r_valid;
  assign axi.axi_r_id     = r_id;
  assign axi.axi_r_data   = r_data;
  assign axi.axi_r_resp   = r_resp;
  assign axi.axi_r_last   = r_last;

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wptr] <= w_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_qcnt     <= '0;
      r_ar_ready <= 1'b0;
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_berr     <= 1'b0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_id       <= '0;
      r_data     <= '0;
      r_resp     <= '0;
      r_last     <= 1'b0;
    end else begin
      r_qcnt     <= w_qcnt_nxt;
      r_ar_ready <= (w_qcnt_nxt != CW'(AR_DEPTH));
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_cur   <= w_head;
            r_berr  <= w_head_berr;
            r_cnt   <= '0;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (!r_valid) begin
            // first beat after a start from IDLE
            r_valid <= 1'b1;
            r_id    <= r_cur.id;
            r_resp  <= f_resp(r_cur.addr, r_berr);
            r_data  <= f_data(r_cur.addr, r_berr);
            r_last  <= (r_cur.len == 8'd0);
          end else if (w_rhs && !w_end) begin
            r_cur.addr <= w_nxt;
            r_cnt      <= r_cnt + 8'd1;
            r_resp     <= f_resp(w_nxt, r_berr);
            r_data     <= f_data(w_nxt, r_berr);
            r_last     <= ((r_cnt + 8'd1) == r_cur.len);
          end else if (w_end && !w_empty) begin
            // chain straight into the next burst
            r_cur  <= w_head;
            r_berr <= w_head_berr;
            r_cnt  <= '0;
            r_id   <= w_head.id;
            r_resp <= f_resp(w_head.addr, w_head_berr);
            r_data <= f_data(w_head.addr, w_head_berr);
            r_last <= (w_head.len == 8'd0);
          end else if (w_end) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
